// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner: rotates rows, debounces a press, emits one strobe per press.
// Strobe arrives DB_CYCLES+1 clocks after the row-settle sample; rotation stalls until debounced release.
module keypad_scan_ctrl #(
  parameter int SCAN_TICKS = 27_000,
  parameter int DB_CYCLES  = 270_000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       scan_en,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_err
);

  localparam int MAXP = (SCAN_TICKS > DB_CYCLES) ? SCAN_TICKS : DB_CYCLES;
  localparam int CW   = $clog2(MAXP);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_DEB  = 2'd1,
    ST_EMIT = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  logic [3:0]    r_sync1, r_cs, r_pat, r_rows_n, r_code;
  state_t        r_state;
  logic [1:0]    r_row;
  logic [CW-1:0] r_dwell, r_cnt;
  logic          r_valid, r_held, r_err;

  state_t        w_state_nxt;
  logic [1:0]    w_row_nxt, w_col;
  logic [CW-1:0] w_dwell_nxt, w_cnt_nxt;
  logic [3:0]    w_pat_nxt, w_code_nxt, w_rows_nxt;
  logic          w_valid_nxt, w_held_nxt, w_err_nxt, w_single;

  // Exactly one low column in the latched pattern identifies a single key.
  always_comb begin
    w_col    = 2'd0;
    w_single = 1'b0;
    case (r_pat)
      4'b1110: begin w_col = 2'd0; w_single = 1'b1; end
      4'b1101: begin w_col = 2'd1; w_single = 1'b1; end
      4'b1011: begin w_col = 2'd2; w_single = 1'b1; end
      4'b0111: begin w_col = 2'd3; w_single = 1'b1; end
      default: begin w_col = 2'd0; w_single = 1'b0; end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_dwell_nxt = r_dwell;
    w_cnt_nxt   = r_cnt;
    w_pat_nxt   = r_pat;
    w_code_nxt  = r_code;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_held_nxt  = r_held;
    case (r_state)
      ST_SCAN: begin
        if (scan_en) begin
          if (r_dwell == SCAN_LAST) begin
            if (r_cs == 4'hF) begin
              w_row_nxt   = r_row + 2'd1;
              w_dwell_nxt = '0;
            end else begin
              w_pat_nxt   = r_cs;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_DEB;
            end
          end else begin
            w_dwell_nxt = r_dwell + CW'(1);
          end
        end
      end
      ST_DEB: begin
        if (r_cs != r_pat) begin
          w_dwell_nxt = '0;
          w_state_nxt = ST_SCAN;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_EMIT: begin
        if (w_single) begin
          w_code_nxt  = {r_row, w_col};
          w_valid_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
        w_held_nxt  = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_REL;
      end
      ST_REL: begin
        if (r_cs == 4'hF) begin
          if (r_cnt == DB_LAST) begin
            w_held_nxt  = 1'b0;
            w_row_nxt   = r_row + 2'd1;
            w_dwell_nxt = '0;
            w_state_nxt = ST_SCAN;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SCAN;
        w_row_nxt   = 2'd0;
        w_dwell_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
    w_rows_nxt = ~(4'b0001 << w_row_nxt);
  end

  // Synchroniser idles high to match the off-chip pull-ups.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync1  <= 4'hF;
      r_cs     <= 4'hF;
      r_state  <= ST_SCAN;
      r_row    <= 2'd0;
      r_dwell  <= '0;
      r_cnt    <= '0;
      r_pat    <= 4'hF;
      r_rows_n <= 4'b1110;
      r_code   <= 4'h0;
      r_valid  <= 1'b0;
      r_held   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sync1  <= cols_n;
      r_cs     <= r_sync1;
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_dwell  <= w_dwell_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pat    <= w_pat_nxt;
      r_rows_n <= w_rows_nxt;
      r_code   <= w_code_nxt;
      r_valid  <= w_valid_nxt;
      r_held   <= w_held_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign rows_n    = r_rows_n;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;
  assign key_err   = r_err;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, strobe scoreboard, vector table and corner sequences.
module tb_keypad_scan_ctrl;

  localparam int ST = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       scan_en;
  logic [3:0] cols_n;
  logic [3:0] rows_n;
  logic [3:0] key_code;
  logic       key_valid, key_held, key_err;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic [15:0] mask;
    logic [3:0]  code;
    logic        err;
  } vec_t;
  vec_t vec[6];

  keypad_scan_ctrl #(.SCAN_TICKS(ST), .DB_CYCLES(DB)) dut (
    .clk(clk), .n_reset(n_reset), .scan_en(scan_en), .cols_n(cols_n),
    .rows_n(rows_n), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .key_err(key_err)
  );

  always #5 clk = ~clk;

  // Key at bit r*4+c pulls column c low while row r is driven.
  always_comb begin
    cols_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !rows_n[r]) cols_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_reset && (key_valid || key_err)) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b code=%0h expected no strobe",
                 key_valid, key_err, key_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_flags", {30'd0, key_valid, key_err}, {30'd0, ~e.err, e.err});
        check("strobe_code", {28'd0, key_code}, {28'd0, e.code});
        check("strobe_held", {31'd0, key_held}, 32'd1);
      end
    end
  end

  task automatic wait_strobe(input string name);
    int s0;
    int n;
    s0 = n_strobe;
    n  = 0;
    while (n_strobe == s0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_strobe_seen"}, {31'd0, n_strobe != s0}, 32'd1);
  endtask

  task automatic wait_held_low(input string name, output int n);
    n = 0;
    while (key_held && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_held_low"}, {31'd0, key_held}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic [3:0] r0;

    vec[0] = '{16'h0001, 4'h0, 1'b0};
    vec[1] = '{16'h0040, 4'h6, 1'b0};
    vec[2] = '{16'h8000, 4'hF, 1'b0};
    vec[3] = '{16'h0200, 4'h9, 1'b0};
    vec[4] = '{16'h0009, 4'h9, 1'b1};
    vec[5] = '{16'h0060, 4'h9, 1'b1};

    n_reset = 1'b0;
    scan_en = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_rows", {28'd0, rows_n}, 32'hE);
    check("rst_code", {28'd0, key_code}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held", {31'd0, key_held}, 32'd0);
    check("rst_err", {31'd0, key_err}, 32'd0);

    // Idle rotation: each row driven for ST cycles.
    n_reset = 1'b1;
    check("rot0", {28'd0, rows_n}, 32'hE);
    for (int k = 1; k < 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("rot%0d", k), {28'd0, rows_n}, {28'd0, ~(4'b0001 << ((k / ST) % 4))});
    end

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{vec[i].code, vec[i].err});
      pressed = vec[i].mask;
      wait_strobe($sformatf("vec%0d", i));
      repeat (5) @(posedge clk);
      #1;
      pressed = '0;
      wait_held_low($sformatf("vec%0d", i), n);
      check($sformatf("vec%0d_q_empty", i), exp_q.size(), 32'd0);
    end

    // Row 2 / col 1: latency from row-2 start, indefinite hold, release timing.
    n = 0;
    while (rows_n != 4'b1110 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    exp_q.push_back('{4'h9, 1'b0});
    pressed = 16'h0200;
    n = 0;
    while (rows_n != 4'b1011 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("row2_reached", {28'd0, rows_n}, 32'hB);
    n = 0;
    while (!key_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, ST + DB + 1);
    repeat (40) @(posedge clk);
    #1;
    check("hold_rows", {28'd0, rows_n}, 32'hB);
    check("hold_held", {31'd0, key_held}, 32'd1);
    pressed = '0;
    wait_held_low("rel9", n);
    check("rel9_cycles", n, DB + 2);
    check("rel9_next_row", {28'd0, rows_n}, 32'h7);

    // Bounce on row 1 / col 2 every 3 clocks, then stable.
    for (int i = 0; i < 13; i++) begin
      pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (3) @(posedge clk);
      #1;
    end
    pressed = 16'h0040;
    exp_q.push_back('{4'h6, 1'b0});
    wait_strobe("bounce");
    repeat (3) @(posedge clk);
    #1;
    pressed = '0;
    wait_held_low("bounce", n);
    check("bounce_q_empty", exp_q.size(), 32'd0);

    // Freeze rotation two cycles into a row, then resume.
    r0 = rows_n;
    n  = 0;
    while (rows_n == r0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    scan_en = 1'b0;
    r0 = rows_n;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rows_n != r0) n++;
    end
    check("freeze_changes", n, 32'd0);
    scan_en = 1'b1;
    n = 0;
    while (rows_n == r0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("resume_cycles", n, ST - 2);

    // Reset asserted mid-cycle while a key is held.
    exp_q.push_back('{4'hF, 1'b0});
    pressed = 16'h8000;
    wait_strobe("k15");
    repeat (40) @(posedge clk);
    #1;
    check("k15_hold_rows", {28'd0, rows_n}, 32'h7);
    check("k15_hold_held", {31'd0, key_held}, 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check("arst_rows", {28'd0, rows_n}, 32'hE);
    check("arst_code", {28'd0, key_code}, 32'h0);
    check("arst_held", {31'd0, key_held}, 32'd0);
    check("arst_valid", {31'd0, key_valid}, 32'd0);
    check("arst_err", {31'd0, key_err}, 32'd0);
    pressed = '0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
